// File: rtl/psram_qpi_ctrl.sv
// Purpose : QPI PSRAM master; after reset sends 0x35 in SPI mode to enter QPI, then serves
//           single read/write requests with sck/ce_n/nibble-wide dio traffic.
// Latency : read accept -> rsp_valid 2*(2+6+READ_DUMMY+8)+1 clocks; write 2*(2+6+2*bytes)+1.
// Backpr. : req_ready only in IDLE; requester holds its request until accepted, none are dropped.
// Ports   : clock/reset (sync, active-high); req_* request channel (valid/ready);
//           rsp_* one-cycle response pulse; sck/ce_n/dio_out/dio_oe/dio_in to the PSRAM pads.
module psram_qpi_ctrl #(
  parameter int READ_DUMMY = 7,
  parameter int CE_GAP     = 2,
  parameter int INIT_DELAY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [23:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sck,
  output logic        ce_n,
  output logic [3:0]  dio_out,
  output logic [3:0]  dio_oe,
  input  logic [3:0]  dio_in
);

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_CMD, GAP, IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, RESP
  } state_t;

  localparam logic [3:0] INIT_LAST  = 4'(INIT_DELAY - 1);
  localparam logic [3:0] GAP_LAST   = 4'(2 * CE_GAP - 1);
  localparam logic [3:0] DUMMY_LAST = 4'(READ_DUMMY - 1);

  state_t      state, state_n, follow;
  logic [3:0]  cnt, cnt_n, last_cnt;
  logic        ph, ph_n;          // 0 = sck low phase, 1 = sck high phase
  logic        lat_wen, lat_err;
  logic [23:0] lat_addr;
  logic [1:0]  lat_size;
  logic [31:0] lat_wdata, rdata_q;
  logic        accept, req_bad, nx_wen;
  logic [23:0] nx_addr, addr_sh;
  logic [31:0] nx_wdata;
  logic        ce_n_d, sck_d;
  logic [3:0]  oe_d, out_d;
  logic [7:0]  cmd_byte, init_sh;

  assign accept  = (state == IDLE) && req_valid;
  assign req_bad = (req_size == 2'd3) ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                   ((req_size == 2'd1) && req_addr[0]);

  // Pad outputs are registered from next-state values, so the accepting cycle
  // must see the incoming request fields before they are latched.
  assign nx_wen   = accept ? req_wen   : lat_wen;
  assign nx_addr  = accept ? req_addr  : lat_addr;
  assign nx_wdata = accept ? req_wdata : lat_wdata;

  // Per serial state: index of the last nibble/period and the state that follows.
  always_comb begin
    last_cnt = 4'd7;
    follow   = RESP;
    case (state)
      INIT_CMD: begin last_cnt = 4'd7; follow = GAP; end
      CMD:      begin last_cnt = 4'd1; follow = ADDR; end
      ADDR:     begin last_cnt = 4'd5; follow = lat_wen ? WDATA : DUMMY; end
      DUMMY:    begin last_cnt = DUMMY_LAST; follow = RDATA; end
      RDATA:    begin last_cnt = 4'd7; follow = RESP; end
      WDATA: begin
        follow = RESP;
        case (lat_size)
          2'd0:    last_cnt = 4'd1;
          2'd1:    last_cnt = 4'd3;
          default: last_cnt = 4'd7;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ph_n    = ph;
    case (state)
      INIT_WAIT: begin
        if (cnt == INIT_LAST) begin state_n = INIT_CMD; cnt_n = 4'd0; ph_n = 1'b0; end
        else cnt_n = cnt + 4'd1;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin state_n = IDLE; cnt_n = 4'd0; end
        else cnt_n = cnt + 4'd1;
      end
      IDLE: begin
        if (accept) begin
          state_n = req_bad ? RESP : CMD;
          cnt_n   = 4'd0;
          ph_n    = 1'b0;
        end
      end
      RESP: begin
        state_n = lat_err ? IDLE : GAP;
        cnt_n   = 4'd0;
        ph_n    = 1'b0;
      end
      INIT_CMD, CMD, ADDR, DUMMY, RDATA, WDATA: begin
        ph_n = ~ph;
        if (ph) begin
          if (cnt == last_cnt) begin state_n = follow; cnt_n = 4'd0; end
          else cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = INIT_WAIT;
    endcase
  end

  // Pad drive for the upcoming cycle. Data nibble order is b0 hi, b0 lo, b1 hi ...
  always_comb begin
    ce_n_d   = 1'b1;
    sck_d    = 1'b0;
    oe_d     = 4'h0;
    out_d    = 4'h0;
    cmd_byte = nx_wen ? 8'h38 : 8'hEB;
    init_sh  = 8'h35 << cnt_n[2:0];
    addr_sh  = nx_addr << {cnt_n[2:0], 2'b00};
    case (state_n)
      INIT_CMD: begin ce_n_d = 1'b0; sck_d = ph_n; oe_d = 4'b0001; out_d = {3'b000, init_sh[7]}; end
      CMD:      begin ce_n_d = 1'b0; sck_d = ph_n; oe_d = 4'hF; out_d = cnt_n[0] ? cmd_byte[3:0] : cmd_byte[7:4]; end
      ADDR:     begin ce_n_d = 1'b0; sck_d = ph_n; oe_d = 4'hF; out_d = addr_sh[23:20]; end
      DUMMY:    begin ce_n_d = 1'b0; sck_d = ph_n; end
      RDATA:    begin ce_n_d = 1'b0; sck_d = ph_n; end
      WDATA:    begin ce_n_d = 1'b0; sck_d = ph_n; oe_d = 4'hF;
                      out_d = nx_wdata[{cnt_n[2:1], ~cnt_n[0], 2'b00} +: 4]; end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT_WAIT;
      cnt       <= 4'd0;
      ph        <= 1'b0;
      ce_n      <= 1'b1;
      sck       <= 1'b0;
      dio_oe    <= 4'h0;
      dio_out   <= 4'h0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      lat_wen   <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= 24'h0;
      lat_size  <= 2'd0;
      lat_wdata <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ph        <= ph_n;
      ce_n      <= ce_n_d;
      sck       <= sck_d;
      dio_oe    <= oe_d;
      dio_out   <= out_d;
      req_ready <= (state_n == IDLE);
      if (accept) begin
        lat_wen   <= req_wen;
        lat_err   <= req_bad;
        lat_addr  <= req_addr;
        lat_size  <= req_size;
        lat_wdata <= req_wdata;
      end
      // Sample on the edge that ends the sck high phase.
      if ((state == RDATA) && ph)
        rdata_q[{cnt[2:1], ~cnt[0], 2'b00} +: 4] <= dio_in;
      rsp_valid <= (state == RESP);
      if (state == RESP) begin
        rsp_err   <= lat_err;
        rsp_rdata <= (lat_wen || lat_err) ? 32'h0 : rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_psram_qpi_ctrl.sv
module tb_psram_qpi_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [23:0] req_addr = 24'h0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sck, ce_n;
  logic [3:0]  dio_out, dio_oe, dio_in;

  int total = 0;
  int bad   = 0;

  psram_qpi_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sck(sck), .ce_n(ce_n), .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in)
  );

  always #5 clock = ~clock;

  // ---------------- PSRAM device model ----------------
  bit          qpi = 1'b0;
  int          n = 0;           // sck rising edges since ce_n fell
  int          ce_falls = 0;
  logic [7:0]  sbits = 8'h0;
  logic [7:0]  mcmd = 8'h0;
  logic [23:0] maddr = 24'h0;
  logic [3:0]  cap [32];
  bit   [7:0]  mem [512];
  logic [8:0]  widx;

  always @(posedge sck or negedge ce_n or posedge reset) begin
    if (reset) begin
      qpi = 1'b0;
      n   = 0;
    end else if (!sck) begin
      n = 0;
      ce_falls++;
    end else begin
      if (n < 32) cap[n] = dio_out;
      if (!qpi) begin
        sbits = {sbits[6:0], dio_out[0]};
        if (n == 7 && sbits == 8'h35) qpi = 1'b1;
      end else if (n < 2) begin
        mcmd = {mcmd[3:0], dio_out};
      end else if (n < 8) begin
        maddr = {maddr[19:0], dio_out};
      end else if (mcmd == 8'h38) begin
        widx = maddr[8:0] + 9'((n - 8) / 2);
        if (((n - 8) % 2) == 0) mem[widx][7:4] = dio_out;
        else                    mem[widx][3:0] = dio_out;
      end
      n++;
    end
  end

  int         rk;
  logic [8:0] ridx;
  logic [7:0] rbyte;
  logic [3:0] drv;
  always_comb begin
    drv   = 4'h0;
    rk    = 0;
    ridx  = 9'h0;
    rbyte = 8'h0;
    if (qpi && mcmd == 8'hEB && n >= 16 && n <= 23) begin
      rk    = n - 16;
      ridx  = maddr[8:0] + 9'(rk / 2);
      rbyte = mem[ridx];
      drv   = rk[0] ? rbyte[3:0] : rbyte[7:4];
    end
  end
  assign dio_in = drv;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input int budget, output int waited);
    waited = 0;
    while (!req_ready && waited < budget) begin
      @(negedge clock);
      waited++;
    end
    chk(tag, 64'(req_ready), 64'd1);
  endtask

  // Issue one request from IDLE; lat = clocks from accepting edge to rsp_valid.
  task automatic do_req(input string tag, input logic w, input logic [23:0] a,
                        input logic [1:0] s, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
    int k, wt;
    lat = -1; rd = 32'h0; er = 1'b0;
    wait_ready({tag, "_ready"}, 100, wt);
    req_valid = 1'b1; req_wen = w; req_addr = a; req_size = s; req_wdata = d;
    @(negedge clock);
    req_valid = 1'b0;
    k = 0;
    while (lat < 0 && k < 200) begin
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err;
      end else begin
        @(negedge clock);
        k++;
      end
    end
    @(negedge clock);
    chk({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int          lat, k, wt;
  logic [31:0] rd;
  logic        er;
  logic [63:0] got;
  int          falls0;

  initial begin
    // reset values
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    chk("rst_sck",       64'(sck),       64'd0);
    chk("rst_ce_n",      64'(ce_n),      64'd1);
    chk("rst_dio_out",   64'(dio_out),   64'd0);
    chk("rst_dio_oe",    64'(dio_oe),    64'd0);

    // init sequence: 4 clocks wait, 16 clocks of 0x35, 4 clocks gap
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("init_wait_ce", 64'(ce_n), 64'd1);
    @(negedge clock);
    chk("init_ce_fall", 64'(ce_n), 64'd0);
    chk("init_oe", 64'(dio_oe), 64'd1);
    k = 0;
    while (!ce_n && k < 100) begin @(negedge clock); k++; end
    chk("init_cmd_len", 64'(k), 64'd16);
    wait_ready("init_ready", 100, wt);
    chk("init_gap", 64'(wt), 64'd4);
    chk("init_bits", 64'(sbits), 64'h35);
    chk("init_sck_cnt", 64'(n), 64'd8);
    chk("init_qpi", 64'(qpi), 64'd1);

    // 4-byte write
    do_req("wr4", 1'b1, 24'h000100, 2'd2, 32'hDEADBEEF, lat, rd, er);
    chk("wr4_lat", 64'(lat), 64'd33);
    chk("wr4_err", 64'(er), 64'd0);
    chk("wr4_rdata", 64'(rd), 64'd0);
    chk("wr4_sck_cnt", 64'(n), 64'd16);
    got = 64'h0;
    for (int i = 0; i < 16; i++) got = {got[59:0], cap[i]};
    chk("wr4_nibbles", got, 64'h38000100EFBEADDE);

    // 4-byte read back
    do_req("rd4", 1'b0, 24'h000100, 2'd2, 32'h0, lat, rd, er);
    chk("rd4_lat", 64'(lat), 64'd47);
    chk("rd4_data", 64'(rd), 64'hDEADBEEF);
    chk("rd4_err", 64'(er), 64'd0);
    chk("rd4_sck_cnt", 64'(n), 64'd23);

    // single-byte write to the top byte, then read the word
    do_req("wr1", 1'b1, 24'h000103, 2'd0, 32'h000000AB, lat, rd, er);
    chk("wr1_lat", 64'(lat), 64'd21);
    chk("wr1_sck_cnt", 64'(n), 64'd10);
    got = 64'h0;
    for (int i = 0; i < 10; i++) got = {got[59:0], cap[i]};
    chk("wr1_nibbles", got, 64'h38000103AB);
    do_req("rd_mix", 1'b0, 24'h000100, 2'd2, 32'h0, lat, rd, er);
    chk("rd_mix_data", 64'(rd), 64'hABADBEEF);

    // misaligned and illegal-size requests: no bus activity, error response
    falls0 = ce_falls;
    do_req("mis", 1'b0, 24'h000102, 2'd2, 32'h0, lat, rd, er);
    chk("mis_lat", 64'(lat), 64'd1);
    chk("mis_err", 64'(er), 64'd1);
    chk("mis_rdata", 64'(rd), 64'd0);
    do_req("sz3", 1'b1, 24'h000100, 2'd3, 32'h12345678, lat, rd, er);
    chk("sz3_err", 64'(er), 64'd1);
    chk("err_no_ce", 64'(ce_falls), 64'(falls0));

    // reset during the address phase of a read
    wait_ready("abort_ready", 100, wt);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 24'h000100; req_size = 2'd2;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("abort_mid_ce", 64'(ce_n), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_ce_n", 64'(ce_n), 64'd1);
    chk("abort_oe", 64'(dio_oe), 64'd0);
    chk("abort_rsp", 64'(rsp_valid), 64'd0);
    chk("abort_sck", 64'(sck), 64'd0);
    reset = 1'b0;
    wait_ready("reinit_ready", 100, wt);
    chk("reinit_len", 64'(wt), 64'd24);
    chk("reinit_qpi", 64'(qpi), 64'd1);
    do_req("rd_post", 1'b0, 24'h000100, 2'd2, 32'h0, lat, rd, er);
    chk("rd_post_lat", 64'(lat), 64'd47);
    chk("rd_post_data", 64'(rd), 64'hABADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
